hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control.sv | 179 +++++++++++++++++
 tb/tb_hazard_control.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// hazard_control
//   Pipeline hazard controller for a 5-stage in-order CPU. It resolves:
//   - load-use hazards (one-cycle stall plus an ID/EX bubble)
//   - taken branches (flush of IF/ID and ID/EX)
//   - multi-cycle multiply/divide occupancy of EX
//   - HALT (pipeline drain, then a permanent halted state)
//   It also keeps a saturating count of stalled cycles.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   id_op1/id_op2    source registers of the ID instruction
//   id_uses_op2      ID instruction reads id_op2
//   id_halt          ID instruction is HALT
//   ex_mem_read      EX instruction is a load
//   ex_write_reg     destination register of the EX instruction
//   ex_branch_taken  branch/jump resolved taken in EX
//   ex_muldiv_start  multiply/divide entered EX this cycle
//   pc_stop, pc_mux_sel, if_id_hold, if_id_flush,
//   id_ex_hold, id_ex_flush, ex_mem_flush   pipeline control (combinational)
//   halted           CPU is halted
//   stall_cycles     saturating count of stalled cycles
module hazard_control #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  id_op1,
    input  logic [3:0]  id_op2,
    input  logic        id_uses_op2,
    input  logic        id_halt,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_write_reg,
    input  logic        ex_branch_taken,
    input  logic        ex_muldiv_start,
    output logic        pc_stop,
    output logic        pc_mux_sel,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MULDIV_WAIT = 2'd1,
        HALT_DRAIN  = 2'd2,
        HALTED      = 2'd3
    } state_t;

    localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);
    localparam logic [3:0] DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    logic        load_use;
    logic        pc_stop_c;
    logic        pc_mux_sel_c;
    logic        if_id_hold_c;
    logic        if_id_flush_c;
    logic        id_ex_hold_c;
    logic        id_ex_flush_c;
    logic        ex_mem_flush_c;
    logic        halted_c;

    // R0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_write_reg != 4'd0) &&
                      ((ex_write_reg == id_op1) ||
                       (id_uses_op2 && (ex_write_reg == id_op2)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pc_stop_c      = 1'b0;
        pc_mux_sel_c   = 1'b0;
        if_id_hold_c   = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_hold_c   = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        halted_c       = 1'b0;

        case (state)
            RUN: begin
                // A taken branch squashes whatever is younger, including a
                // HALT or a load-use victim sitting in ID, so it wins outright.
                if (ex_branch_taken) begin
                    pc_mux_sel_c  = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (ex_muldiv_start) begin
                    state_nxt = MULDIV_WAIT;
                    cnt_nxt   = MULDIV_LOAD;
                end else if (id_halt) begin
                    pc_stop_c     = 1'b1;
                    if_id_flush_c = 1'b1;
                    state_nxt     = HALT_DRAIN;
                    cnt_nxt       = DRAIN_LOAD;
                end else if (load_use) begin
                    pc_stop_c     = 1'b1;
                    if_id_hold_c  = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            end

            MULDIV_WAIT: begin
                // cnt counts down from MULDIV_CYCLES-1; the cnt==0 cycle still
                // stalls, giving exactly MULDIV_CYCLES stalled cycles.
                pc_stop_c      = 1'b1;
                if_id_hold_c   = 1'b1;
                id_ex_hold_c   = 1'b1;
                ex_mem_flush_c = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end

            HALT_DRAIN: begin
                pc_stop_c     = 1'b1;
                if_id_flush_c = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = HALTED;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end

            HALTED: begin
                halted_c  = 1'b1;
                pc_stop_c = 1'b1;
            end

            default: begin
                state_nxt = RUN;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even though the state
    // register already reads RUN, because RUN decodes live inputs.
    assign pc_stop      = reset & pc_stop_c;
    assign pc_mux_sel   = reset & pc_mux_sel_c;
    assign if_id_hold   = reset & if_id_hold_c;
    assign if_id_flush  = reset & if_id_flush_c;
    assign id_ex_hold   = reset & id_ex_hold_c;
    assign id_ex_flush  = reset & id_ex_flush_c;
    assign ex_mem_flush = reset & ex_mem_flush_c;
    assign halted       = reset & halted_c;

    // Cycles spent halted are not stalls; the counter sticks at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 16'd0;
        end else if (pc_stop_c && (state != HALTED) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

    localparam int MULDIV_CYCLES = 4;
    localparam int DRAIN_CYCLES  = 3;

    logic        clock;
    logic        reset;
    logic [3:0]  id_op1;
    logic [3:0]  id_op2;
    logic        id_uses_op2;
    logic        id_halt;
    logic        ex_mem_read;
    logic [3:0]  ex_write_reg;
    logic        ex_branch_taken;
    logic        ex_muldiv_start;
    logic        pc_stop;
    logic        pc_mux_sel;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_hold;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        halted;
    logic [15:0] stall_cycles;

    hazard_control #(
        .MULDIV_CYCLES (MULDIV_CYCLES),
        .DRAIN_CYCLES  (DRAIN_CYCLES)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .id_op1          (id_op1),
        .id_op2          (id_op2),
        .id_uses_op2     (id_uses_op2),
        .id_halt         (id_halt),
        .ex_mem_read     (ex_mem_read),
        .ex_write_reg    (ex_write_reg),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_start (ex_muldiv_start),
        .pc_stop         (pc_stop),
        .pc_mux_sel      (pc_mux_sel),
        .if_id_hold      (if_id_hold),
        .if_id_flush     (if_id_flush),
        .id_ex_hold      (id_ex_hold),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .halted          (halted),
        .stall_cycles    (stall_cycles)
    );

    typedef struct packed {
        logic        pc_stop;
        logic        pc_mux_sel;
        logic        if_id_hold;
        logic        if_id_flush;
        logic        id_ex_hold;
        logic        id_ex_flush;
        logic        ex_mem_flush;
        logic        halted;
        logic [15:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: remaining cycles of each multi-cycle activity.
    bit   m_halted     = 0;
    int   m_muldiv_left = 0;
    int   m_drain_left  = 0;
    int   m_stalls      = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs just after the rising edge and queue the
    // expected outputs for that cycle, then advance the model across the
    // edge that will consume these inputs.
    task automatic apply(input logic rst_v, input logic [3:0] op1, input logic [3:0] op2,
                         input logic uses2, input logic halt, input logic mrd,
                         input logic [3:0] wr, input logic br, input logic md);
        exp_t e;
        @(posedge clock);
        #1;
        reset           = rst_v;
        id_op1          = op1;
        id_op2          = op2;
        id_uses_op2     = uses2;
        id_halt         = halt;
        ex_mem_read     = mrd;
        ex_write_reg    = wr;
        ex_branch_taken = br;
        ex_muldiv_start = md;
        e = '0;
        if (!rst_v) begin
            m_halted      = 0;
            m_muldiv_left = 0;
            m_drain_left  = 0;
            m_stalls      = 0;
        end else begin
            e.stall = 16'(m_stalls);
            if (m_halted) begin
                e.halted  = 1'b1;
                e.pc_stop = 1'b1;
            end else if (m_muldiv_left > 0) begin
                e.pc_stop      = 1'b1;
                e.if_id_hold   = 1'b1;
                e.id_ex_hold   = 1'b1;
                e.ex_mem_flush = 1'b1;
                m_muldiv_left--;
            end else if (m_drain_left > 0) begin
                e.pc_stop     = 1'b1;
                e.if_id_flush = 1'b1;
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end else if (br) begin
                e.pc_mux_sel  = 1'b1;
                e.if_id_flush = 1'b1;
                e.id_ex_flush = 1'b1;
            end else if (md) begin
                m_muldiv_left = MULDIV_CYCLES;
            end else if (halt) begin
                e.pc_stop     = 1'b1;
                e.if_id_flush = 1'b1;
                m_drain_left  = DRAIN_CYCLES;
            end else if (mrd && wr != 0 && (wr == op1 || (uses2 && wr == op2))) begin
                e.pc_stop     = 1'b1;
                e.if_id_hold  = 1'b1;
                e.id_ex_flush = 1'b1;
            end
            if (e.pc_stop && !e.halted && m_stalls < 65535) m_stalls++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pc_stop, pc_mux_sel, if_id_hold, if_id_flush, id_ex_hold,
                     id_ex_flush, ex_mem_flush, halted, stall_cycles};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs @%0t: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                             $time, a[23:16], a.stall, e[23:16], e.stall);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        id_op1 = '0; id_op2 = '0; id_uses_op2 = 1'b0; id_halt = 1'b0;
        ex_mem_read = 1'b0; ex_write_reg = '0; ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0;

        do_reset();
        check_val("reset_stall_cnt", stall_cycles, 16'd0);
        check_val("reset_halted", {15'd0, halted}, 16'd0);

        // Load r3 with id_op1=3: one stall cycle.
        apply(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        idle();
        check_val("load_use_stall_cnt", stall_cycles, 16'd1);
        // Load r0 with id_op1=0: no stall.
        apply(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        // Load r5, id_op2=5 but op2 unused: no stall.
        apply(1'b1, 4'd1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        idle();
        check_val("no_stall_r0_op2", stall_cycles, 16'd1);
        // Load r5 with op2 used: stalls.
        apply(1'b1, 4'd1, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        idle();
        check_val("op2_stall_cnt", stall_cycles, 16'd2);

        // Multiply/divide: 4 stall cycles, inputs ignored meanwhile.
        apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        apply(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
        idle(); idle(); idle();
        idle();
        check_val("muldiv_stall_cnt", stall_cycles, 16'd6);

        // Branch with load-use, then branch with halt: flush only, stay RUN.
        apply(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        apply(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        idle();
        check_val("branch_no_stall_cnt", stall_cycles, 16'd6);
        check_val("branch_halt_not_halted", {15'd0, halted}, 16'd0);

        // HALT: halted rises on the 4th edge and sticks.
        apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(); idle(); idle();
        check_val("halted_before_4th_edge", {15'd0, halted}, 16'd0);
        apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check_val("halted_after_4th_edge", {15'd0, halted}, 16'd1);
        apply(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        check_val("halted_stall_frozen", stall_cycles, 16'd10);

        // Reset in the middle of HALT_DRAIN and of MULDIV_WAIT.
        do_reset();
        apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle();
        apply(1'b0, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        idle();
        apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        idle();
        apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(); idle();

        // Randomized traffic with small register numbers for frequent overlaps.
        for (int i = 0; i < 3000; i++) begin
            apply(1'b1 ^ ($urandom_range(0, 79) == 0),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 11) == 0));
        end

        // Saturation: hold a load-use hazard long enough to pass 16'hFFFF.
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            apply(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        end
        idle();
        check_val("stall_saturates", stall_cycles, 16'hFFFF);

        @(negedge clock);
        #1;
        check_val("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
